slot_spin_ctrl: RTL and testbench
=================================

SLOT_SPIN_CTRL -- requirements
Module: slot_spin_ctrl

Interface
REQ-001 SHALL have parameter STOP_DELAY, default 8, meaning clock cycles between successive reel stops (legal range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port spin_btn  input  1  spin request, already synchronized and debounced, sampled every edge.
REQ-005 SHALL have port rand_digit  input  4  free-running digit source, values 0..9.
REQ-006 SHALL have ports reel0, reel1, reel2  output  4 each  registered reel display values.
REQ-007 SHALL have port busy  output  1  high while a spin is in progress (states REEL0..EVAL).
REQ-008 SHALL have port result_valid  output  1  one-cycle pulse when the spin outcome is final.
REQ-009 SHALL have port win  output  2  outcome: 0 = none, 1 = pair, 2 = triple; 3 never driven.
REQ-010 SHALL have port credits  output  8  registered credit balance.

Function
REQ-011 SHALL implement FSM states IDLE, REEL0, REEL1, REEL2, EVAL; 8-bit stop counter cnt.
REQ-012 In IDLE, an edge with spin_btn=1 and credits>0 SHALL accept the spin:
- state -> REEL0, cnt -> 0, credits -> credits-1, win -> 0, busy -> 1.
REQ-013 In IDLE, spin_btn=1 with credits=0 SHALL be ignored; no register changes.
REQ-014 spin_btn SHALL be ignored in every state other than IDLE; no queuing.
REQ-015 In state REELk, every edge SHALL load rand_digit into reel k and into every reel j>k; reels j<k SHALL hold.
REQ-016 In REELk, cnt SHALL increment each edge.
- When cnt==STOP_DELAY-1 at an edge, reel k loads rand_digit (final value), cnt -> 0, state advances (REEL0->REEL1->REEL2->EVAL).
REQ-017 Stop timing: with the spin accepted at edge E0, reel0/reel1/reel2 final values SHALL be rand_digit sampled at edges E0+STOP_DELAY, E0+2*STOP_DELAY and E0+3*STOP_DELAY.
REQ-018 In EVAL, one edge (E0+3*STOP_DELAY+1) SHALL register win, update credits, set result_valid=1, busy=0, state -> IDLE.
REQ-019 win SHALL be 2 if reel0==reel1==reel2, else 1 if any two reels are equal, else 0.
REQ-020 Payout SHALL be +10 for triple, +2 for pair, +0 otherwise, saturating at 255 (9-bit intermediate, clamp).
REQ-021 result_valid SHALL deassert on the next edge; win and reels SHALL hold until the next accepted spin.
REQ-022 A spin_btn=1 on the edge where result_valid is high (state IDLE) SHALL be accepted per REQ-012.
REQ-023 Out-of-range rand_digit (10..15) SHALL be loaded unmodified; the compare rules still apply.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, cnt=0, reel0=reel1=reel2=0, busy=0, result_valid=0, win=0, credits=10.
REQ-025 Reset asserted mid-spin SHALL abort the spin with no payout and no refund of the deducted credit; credits return to 10.
REQ-026 The first spin SHALL be accepted on the first edge after rst deasserts if spin_btn=1.

Verification (STOP_DELAY=4)
REQ-027 Reset check: assert rst asynchronously between edges -> all outputs take REQ-024 values before the next edge.
REQ-028 Triple: rand_digit held at 7, one spin pulse at E0 -> reels 7,7,7 frozen.
- result_valid high only after edge E0+13; win=2; credits 10->9->19.
REQ-029 Mismatch: rand_digit=1 at edge E0+4, 2 at E0+8, 3 at E0+12 -> reels 1,2,3; win=0; credits 9.
- reel1/reel2 track rand_digit between stops.
REQ-030 Pair plus busy-ignore: digits 5,5,6 at the stop edges; spin_btn pulsed at E0+2 and E0+10.
- Expect win=1 and credits 10-1+2=11; exactly one deduction.
REQ-031 Credit exhaustion and saturation:
- 10 losing spins -> credits 0; 11th spin ignored, busy stays 0.
- After reset, 28 consecutive triples -> credits 255, unchanged by a further triple (254 after deduction, then clamped to 255).
REQ-032 Reset mid-spin: rst at E0+6 -> reel0 returns 0, busy 0, credits 10, no result_valid pulse; next spin proceeds normally.

Source files
------------

// File: rtl/slot_spin_ctrl.sv
// Three-reel slot machine spin controller: accepts a paid spin, stops the
// reels one after another every STOP_DELAY cycles, then scores the outcome and pays out.
module slot_spin_ctrl #(
    parameter int unsigned STOP_DELAY = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin_btn,
    input  logic [3:0] rand_digit,
    output logic [3:0] reel0,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic       busy,
    output logic       result_valid,
    output logic [1:0] win,
    output logic [7:0] credits
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REEL0 = 3'd1,
        REEL1 = 3'd2,
        REEL2 = 3'd3,
        EVAL  = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CNT     = 8'(STOP_DELAY - 1);
    localparam logic [7:0] RESET_CREDIT = 8'd10;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic       accept;
    logic       stop;
    logic       triple;
    logic       pair;
    logic [1:0] win_eval;
    logic [8:0] payout_sum;
    logic [7:0] credits_eval;

    assign accept = (state == IDLE) && spin_btn && (credits != 8'd0);
    assign stop   = (cnt == LAST_CNT);

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    // NOTE: the default at the top of each always_comb keeps every path
    // assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = REEL0;
            REEL0:   if (stop)   state_next = REEL1;
            REEL1:   if (stop)   state_next = REEL2;
            REEL2:   if (stop)   state_next = EVAL;
            EVAL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state, and the outcome scoring used in EVAL
    always_comb begin
        busy     = (state != IDLE);
        triple   = (reel0 == reel1) && (reel1 == reel2);
        pair     = (reel0 == reel1) || (reel1 == reel2) || (reel0 == reel2);
        win_eval = 2'd0;
        if (triple)    win_eval = 2'd2;
        else if (pair) win_eval = 2'd1;
        payout_sum = {1'b0, credits};
        if (triple)    payout_sum = {1'b0, credits} + 9'd10;
        else if (pair) payout_sum = {1'b0, credits} + 9'd2;
        credits_eval = payout_sum[8] ? 8'hFF : payout_sum[7:0];
    end

    // Datapath: stop counter, reels, outcome and credit balance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 8'd0;
            reel0        <= 4'd0;
            reel1        <= 4'd0;
            reel2        <= 4'd0;
            result_valid <= 1'b0;
            win          <= 2'd0;
            credits      <= RESET_CREDIT;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= 8'd0;
                        credits <= credits - 8'd1;
                        win     <= 2'd0;
                    end
                end
                REEL0: begin
                    cnt   <= stop ? 8'd0 : cnt + 8'd1;
                    reel0 <= rand_digit;
                    reel1 <= rand_digit;
                    reel2 <= rand_digit;
                end
                REEL1: begin
                    cnt   <= stop ? 8'd0 : cnt + 8'd1;
                    reel1 <= rand_digit;
                    reel2 <= rand_digit;
                end
                REEL2: begin
                    cnt   <= stop ? 8'd0 : cnt + 8'd1;
                    reel2 <= rand_digit;
                end
                EVAL: begin
                    win          <= win_eval;
                    credits      <= credits_eval;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Directed, table-driven bench for slot_spin_ctrl with STOP_DELAY=4:
// scored spins, busy-time button presses, async reset, credit exhaustion and saturation.
module tb_slot_spin_ctrl;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic       spin_btn;
    logic [3:0] rand_digit;
    logic [3:0] reel0;
    logic [3:0] reel1;
    logic [3:0] reel2;
    logic       busy;
    logic       result_valid;
    logic [1:0] win;
    logic [7:0] credits;

    int n_pass  = 0;
    int n_total = 0;

    slot_spin_ctrl #(.STOP_DELAY(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .spin_btn     (spin_btn),
        .rand_digit   (rand_digit),
        .reel0        (reel0),
        .reel1        (reel1),
        .reel2        (reel2),
        .busy         (busy),
        .result_valid (result_valid),
        .win          (win),
        .credits      (credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        bit         extra;
        logic [1:0] win;
        logic [7:0] credits;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " reel0"}, reel0, 0);
        check({tag, " reel1"}, reel1, 0);
        check({tag, " reel2"}, reel2, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " win"}, win, 0);
        check({tag, " credits"}, credits, 10);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // One spin from acceptance edge E0 through the EVAL edge E0+13.
    // Non-stop edges drive digit value i so reel tracking is visible.
    task automatic run_spin(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input bit extra);
        spin_btn   = 1'b1;
        rand_digit = 4'd0;
        tick();
        check("accept busy", busy, 1);
        check("accept win cleared", win, 0);
        check("accept result_valid low", result_valid, 0);
        spin_btn = 1'b0;
        for (int i = 1; i <= 3 * SD + 1; i++) begin
            if (i == SD)          rand_digit = d0;
            else if (i == 2 * SD) rand_digit = d1;
            else if (i == 3 * SD) rand_digit = d2;
            else                  rand_digit = 4'(i);
            spin_btn = extra && (i == 2 || i == 10);
            tick();
            if (i == 6) begin
                check("reel0 frozen", reel0, d0);
                check("reel1 tracking", reel1, 6);
                check("reel2 tracking", reel2, 6);
            end
            if (i == 10) begin
                check("reel1 frozen", reel1, d1);
                check("reel2 tracking late", reel2, 10);
            end
            if (i == 3 * SD) begin
                check("pre-eval busy", busy, 1);
                check("pre-eval result_valid", result_valid, 0);
            end
            if (i == 3 * SD + 1) begin
                check("eval busy", busy, 0);
                check("eval result_valid", result_valid, 1);
            end
        end
        spin_btn = 1'b0;
    endtask

    initial begin
        int rv_seen;

        vecs[0] = '{4'd7,  4'd7,  4'd7,  1'b0, 2'd2, 8'd19};
        vecs[1] = '{4'd1,  4'd2,  4'd3,  1'b0, 2'd0, 8'd18};
        vecs[2] = '{4'd5,  4'd5,  4'd6,  1'b1, 2'd1, 8'd19};
        vecs[3] = '{4'd4,  4'd9,  4'd4,  1'b0, 2'd1, 8'd20};
        vecs[4] = '{4'd3,  4'd8,  4'd8,  1'b0, 2'd1, 8'd21};
        vecs[5] = '{4'd12, 4'd12, 4'd12, 1'b0, 2'd2, 8'd30};
        vecs[6] = '{4'd0,  4'd1,  4'd2,  1'b0, 2'd0, 8'd29};
        vecs[7] = '{4'd15, 4'd3,  4'd15, 1'b0, 2'd1, 8'd30};

        rst        = 1'b0;
        spin_btn   = 1'b0;
        rand_digit = 4'd0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 check_reset_state("por");
        tick();
        tick();
        rst = 1'b0;

        // Back-to-back spins: each new spin is accepted while result_valid is high
        for (int v = 0; v < 8; v++) begin
            run_spin(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].extra);
            check($sformatf("vec%0d win", v), win, vecs[v].win);
            check($sformatf("vec%0d credits", v), credits, vecs[v].credits);
            check($sformatf("vec%0d reel0", v), reel0, vecs[v].d0);
            check($sformatf("vec%0d reel1", v), reel1, vecs[v].d1);
            check($sformatf("vec%0d reel2", v), reel2, vecs[v].d2);
        end

        // Pulse ends after one cycle; outcome holds
        tick();
        check("rv deassert", result_valid, 0);
        check("win hold", win, 1);
        check("reel0 hold", reel0, 15);
        check("reel2 hold", reel2, 15);
        check("credits hold", credits, 30);

        // Reset mid-spin, asserted between edges
        spin_btn = 1'b1;
        tick();
        spin_btn   = 1'b0;
        rand_digit = 4'd9;
        repeat (5) tick();
        check("mid-spin reel0 loaded", reel0, 9);
        #3 rst = 1'b1;
        #1 check_reset_state("midspin");
        tick();
        rst = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_valid || busy) rv_seen++;
        end
        check("no activity after abort", rv_seen, 0);
        run_spin(4'd2, 4'd2, 4'd2, 1'b0);
        check("post-abort win", win, 2);
        check("post-abort credits", credits, 19);

        // Credit exhaustion
        pulse_reset();
        for (int s = 0; s < 10; s++) run_spin(4'd0, 4'd1, 4'd2, 1'b0);
        check("exhaust credits", credits, 0);
        check("exhaust win", win, 0);
        spin_btn = 1'b1;
        tick();
        check("no-credit busy", busy, 0);
        check("no-credit credits", credits, 0);
        repeat (3) tick();
        check("no-credit busy later", busy, 0);
        check("no-credit rv", result_valid, 0);
        spin_btn = 1'b0;
        tick();

        // Saturation at 255
        pulse_reset();
        for (int s = 0; s < 27; s++) run_spin(4'd3, 4'd3, 4'd3, 1'b0);
        check("sat 27 triples", credits, 253);
        run_spin(4'd3, 4'd3, 4'd3, 1'b0);
        check("sat 28 triples", credits, 255);
        run_spin(4'd8, 4'd8, 4'd8, 1'b0);
        check("sat clamp", credits, 255);
        check("sat win", win, 2);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
